uart_param_decoder: RTL
=======================

Name: uart_param_decoder

Overview:
- Upstream stage of the DDS signal path. Receives 8N1 UART command frames from the host PC and decodes them.
- Holds the three generator parameters in registers: tuning word phase_M, amplitude signal_A in mV, and signal_shape.
- These parameters drive the phase accumulator, the phase-to-amplitude LUT and the amplitude control stage.
- Runs in the 1 MHz DDS clock domain. Replaces hard-coded parameter selection with runtime control.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit (1 MHz / 9600 baud).
- TIMEOUT_CLKS, 20000, idle clocks between bytes of a frame before the parser aborts.
- M_DEFAULT, 13'd41, phase_M reset value.
- A_DEFAULT, 11'd1000, signal_A reset value, in mV.
- A_MAX, 11'd1650, upper clamp for signal_A, in mV.

Ports:
- clk  in  1  1 MHz system clock
- rst  in  1  asynchronous, active-low reset
- uart_rx  in  1  serial input; idles high; asynchronous to clk
- uart_tx  out  1  serial output; see Optional Feature
- phase_M  out  13  phase increment for the accumulator
- signal_A  out  11  amplitude in mV
- signal_shape  out  2  0 sine, 1 triangle, 2 square, 3 sawtooth
- param_update  out  1  one-cycle pulse when any parameter register is written
- frame_err  out  1  one-cycle pulse when a frame or byte is rejected

Behaviour:
- Reset (rst=0, async): phase_M=M_DEFAULT, signal_A=A_DEFAULT, signal_shape=0, param_update=0, frame_err=0, uart_tx=1, all FSMs idle. Synchronizer flops reset to 1.
- RX front end: uart_rx passes through a 2-FF synchronizer.
- RX byte FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE -> R_START on a synchronized high-to-low transition.
  - R_START: re-check the line at CLKS_PER_BIT/2. If high, the start was a glitch; return to R_IDLE silently.
  - R_DATA: sample 8 bits, LSB first, every CLKS_PER_BIT counted from the start-bit centre.
  - R_STOP: sample the stop bit. If 1, emit an internal byte strobe. If 0, pulse frame_err, drop the byte and reset the parser.
- Frame format: 0xA5, CMD, D_HI, D_LO, CHK, where CHK = CMD ^ D_HI ^ D_LO.
- Parser FSM states: P_HDR, P_CMD, P_DHI, P_DLO, P_CHK, P_APPLY.
  - P_HDR discards every byte other than 0xA5; no error is raised.
  - Each later state advances on a byte strobe.
  - P_CHK: a checksum mismatch pulses frame_err and returns to P_HDR.
- P_APPLY (single cycle; registers update and param_update pulses on the cycle after the CHK byte strobe):
  - CMD 0x01: phase_M = {D_HI[4:0], D_LO}.
  - CMD 0x02: signal_A = min({D_HI[2:0], D_LO}, A_MAX).
  - CMD 0x03: signal_shape = D_LO[1:0].
  - Any other CMD: frame_err pulses; no register changes.
  - Unused upper data bits are ignored.
- Timeout: the counter resets on every byte strobe and counts only while the parser is not in P_HDR. At TIMEOUT_CLKS it pulses frame_err and forces P_HDR.
- A 0xA5 received mid-frame is treated as data, not resync. Recovery is by checksum failure or timeout.
- param_update and frame_err are never both high in the same cycle.
- Outputs are registered and stable between updates. Downstream blocks sample them directly; all stages share one clock, so no CDC is needed.
- Reset mid-frame: everything returns to reset values immediately; a partial frame is lost.

Optional Feature:
- Macro: PARAM_ECHO_EN.
- Defined: a UART TX FSM (T_IDLE, T_START, T_DATA, T_STOP, same CLKS_PER_BIT) sends an acknowledge byte.
  - Sends 0x06 (ACK) after each applied frame.
  - Sends 0x15 (NAK) after each checksum, command or stop-bit error.
  - A new request while TX is busy is dropped; no queue.
  - Timeouts send nothing.
- Not defined: uart_tx is tied to 1; no TX logic is synthesized.

Test Plan:
- Reset release, no input -> phase_M=41, signal_A=1000, signal_shape=0, uart_tx=1, no pulses.
- Frame A5 01 03 E8 EA -> phase_M=13'h3E8; param_update pulses once, one cycle after the CHK byte stop bit; with PARAM_ECHO_EN, uart_tx sends 0x06.
- Frame A5 02 07 D0 D5 (2000 mV) -> signal_A clamped to 1650; then A5 03 00 02 01 -> signal_shape=2.
- Frame A5 01 00 10 00 (bad CHK) -> frame_err pulses; phase_M unchanged; NAK 0x15 with the macro.
- Send A5 01 then idle >20000 clk, then a valid A5 03 00 01 02 -> frame_err on timeout; then signal_shape=1.
- 20-clk low glitch on uart_rx, and separately a byte with stop bit 0 -> glitch ignored with no error; bad stop bit gives frame_err; garbage bytes 0x00 0xFF before A5 are ignored.

Source files
------------

// File: rtl/uart_param_decoder.sv
// UART 8N1 command decoder that holds the DDS generator parameters (phase_M, signal_A, signal_shape).
// Optional macro PARAM_ECHO_EN adds a UART transmitter that answers each frame with ACK/NAK.
module uart_param_decoder #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned TIMEOUT_CLKS = 20000,
  parameter logic [12:0] M_DEFAULT    = 13'd41,
  parameter logic [10:0] A_DEFAULT    = 11'd1000,
  parameter logic [10:0] A_MAX        = 11'd1650
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [12:0] phase_M,
  output logic [10:0] signal_A,
  output logic [1:0]  signal_shape,
  output logic        param_update,
  output logic        frame_err
);

  localparam int unsigned BIT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]       HDR_BYTE  = 8'hA5;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  rx_state_e        rx_state_q, rx_state_d;
  logic [BIT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_stb_c, stop_err_c;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + BIT_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_stb_c = 1'b0;
    stop_err_c = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = R_START;
      end
      R_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = R_IDLE;
          byte_stb_c = rx_s2_q;
          stop_err_c = !rx_s2_q;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  typedef enum logic [2:0] {P_HDR, P_CMD, P_DHI, P_DLO, P_CHK, P_APPLY} p_state_e;

  p_state_e        p_state_q, p_state_d;
  logic [7:0]      cmd_q, cmd_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [12:0]     phase_m_q, phase_m_d;
  logic [10:0]     signal_a_q, signal_a_d;
  logic [1:0]      shape_q, shape_d;
  logic            param_update_q, param_update_d;
  logic            frame_err_q, frame_err_d;
  logic            to_fire_c, chk_err_c, cmd_err_c;
  logic [10:0]     a_req_c;

  always_comb begin
    p_state_d      = p_state_q;
    cmd_d          = cmd_q;
    dhi_d          = dhi_q;
    dlo_d          = dlo_q;
    to_cnt_d       = '0;
    phase_m_d      = phase_m_q;
    signal_a_d     = signal_a_q;
    shape_d        = shape_q;
    param_update_d = 1'b0;
    chk_err_c      = 1'b0;
    cmd_err_c      = 1'b0;
    to_fire_c      = 1'b0;
    a_req_c        = {dhi_q[2:0], dlo_q};

    // Inter-byte timeout only runs while a frame is in progress
    if (p_state_q != P_HDR && !byte_stb_c) begin
      to_cnt_d  = to_cnt_q + TO_W'(1);
      to_fire_c = (to_cnt_q == TO_LAST);
    end

    case (p_state_q)
      P_HDR: if (byte_stb_c && rx_shift_q == HDR_BYTE) p_state_d = P_CMD;
      P_CMD: if (byte_stb_c) begin
        cmd_d     = rx_shift_q;
        p_state_d = P_DHI;
      end
      P_DHI: if (byte_stb_c) begin
        dhi_d     = rx_shift_q;
        p_state_d = P_DLO;
      end
      P_DLO: if (byte_stb_c) begin
        dlo_d     = rx_shift_q;
        p_state_d = P_CHK;
      end
      P_CHK: if (byte_stb_c) begin
        if (rx_shift_q == (cmd_q ^ dhi_q ^ dlo_q)) begin
          p_state_d = P_APPLY;
        end else begin
          chk_err_c = 1'b1;
          p_state_d = P_HDR;
        end
      end
      P_APPLY: begin
        p_state_d      = P_HDR;
        param_update_d = 1'b1;
        case (cmd_q)
          8'h01:   phase_m_d  = {dhi_q[4:0], dlo_q};
          8'h02:   signal_a_d = (a_req_c > A_MAX) ? A_MAX : a_req_c;
          8'h03:   shape_d    = dlo_q[1:0];
          default: begin
            cmd_err_c      = 1'b1;
            param_update_d = 1'b0;
          end
        endcase
      end
      default: p_state_d = P_HDR;
    endcase

    if (stop_err_c || to_fire_c) p_state_d = P_HDR;
    // An update always wins so the two pulses are mutually exclusive
    frame_err_d = (stop_err_c || to_fire_c || chk_err_c || cmd_err_c) && !param_update_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_state_q      <= P_HDR;
      cmd_q          <= '0;
      dhi_q          <= '0;
      dlo_q          <= '0;
      to_cnt_q       <= '0;
      phase_m_q      <= M_DEFAULT;
      signal_a_q     <= A_DEFAULT;
      shape_q        <= 2'd0;
      param_update_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      p_state_q      <= p_state_d;
      cmd_q          <= cmd_d;
      dhi_q          <= dhi_d;
      dlo_q          <= dlo_d;
      to_cnt_q       <= to_cnt_d;
      phase_m_q      <= phase_m_d;
      signal_a_q     <= signal_a_d;
      shape_q        <= shape_d;
      param_update_q <= param_update_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign phase_M      = phase_m_q;
  assign signal_A     = signal_a_q;
  assign signal_shape = shape_q;
  assign param_update = param_update_q;
  assign frame_err    = frame_err_q;

`ifdef PARAM_ECHO_EN
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [BIT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;
  logic             ack_req_c, nak_req_c;

  // Timeouts are silent; every other rejection answers with NAK
  assign ack_req_c = param_update_d;
  assign nak_req_c = frame_err_d && !to_fire_c;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + BIT_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      T_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (ack_req_c || nak_req_c) begin
          tx_shift_d = ack_req_c ? 8'h06 : 8'h15;
          tx_state_d = T_START;
          tx_d       = 1'b0;
        end
      end
      T_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_state_d = T_DATA;
        end
      end
      T_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = T_STOP;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end
      end
      T_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = T_IDLE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign uart_tx = tx_q;
`else
  assign uart_tx = 1'b1;
`endif

endmodule
